// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner with press/release debounce.
// Presents one decoded key at a time on key_valid/key_code.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV        = 125000,
  parameter int unsigned DEBOUNCE_CYCLES = 2500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic       key_valid,
  output logic [3:0] key_code
);

  localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] SLOT_ONE  = SW'(1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] DEB_ONE   = DW'(1);

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_PRESSED,
    ST_RELEASE
  } state_t;

  state_t        state_q;
  logic [3:0]    row_m_q;
  logic [3:0]    row_s_q;
  logic [SW-1:0] slot_q;
  logic [DW-1:0] deb_q;
  logic [1:0]    col_idx_q;
  logic [3:0]    col_q;
  logic [3:0]    pat_q;
  logic [3:0]    code_lat_q;
  logic          key_valid_q;
  logic [3:0]    key_code_q;

  logic          one_low;
  logic [1:0]    row_idx;
  logic [3:0]    dec_code;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_m_q <= '1;
      row_s_q <= '1;
    end else begin
      row_m_q <= row_in;
      row_s_q <= row_m_q;
    end
  end

  always_comb begin
    one_low = 1'b1;
    row_idx = 2'd0;
    case (row_s_q)
      4'b1110: row_idx = 2'd0;
      4'b1101: row_idx = 2'd1;
      4'b1011: row_idx = 2'd2;
      4'b0111: row_idx = 2'd3;
      default: one_low = 1'b0;
    endcase
  end

  always_comb begin
    dec_code = 4'h0;
    case ({row_idx, col_idx_q})
      4'b00_00: dec_code = 4'h1;
      4'b00_01: dec_code = 4'h2;
      4'b00_10: dec_code = 4'h3;
      4'b00_11: dec_code = 4'hC;
      4'b01_00: dec_code = 4'h4;
      4'b01_01: dec_code = 4'h5;
      4'b01_10: dec_code = 4'h6;
      4'b01_11: dec_code = 4'hD;
      4'b10_00: dec_code = 4'h7;
      4'b10_01: dec_code = 4'h8;
      4'b10_10: dec_code = 4'h9;
      4'b10_11: dec_code = 4'hE;
      4'b11_00: dec_code = 4'hA;
      4'b11_01: dec_code = 4'h0;
      4'b11_10: dec_code = 4'hB;
      default:  dec_code = 4'hF;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_SCAN;
      slot_q      <= '0;
      deb_q       <= '0;
      col_idx_q   <= 2'd0;
      col_q       <= 4'b1110;
      pat_q       <= '1;
      code_lat_q  <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
    end else begin
      case (state_q)
        ST_SCAN: begin
          if (slot_q == SLOT_LAST) begin
            slot_q <= '0;
            if (one_low) begin
              pat_q      <= row_s_q;
              code_lat_q <= dec_code;
              deb_q      <= '0;
              state_q    <= ST_DEBOUNCE;
            end else begin
              col_q     <= {col_q[2:0], col_q[3]};
              col_idx_q <= col_idx_q + 2'd1;
            end
          end else begin
            slot_q <= slot_q + SLOT_ONE;
          end
        end
        ST_DEBOUNCE: begin
          if (row_s_q == pat_q) begin
            if (deb_q == DEB_LAST) begin
              state_q     <= ST_PRESSED;
              key_valid_q <= 1'b1;
              key_code_q  <= code_lat_q;
            end else begin
              deb_q <= deb_q + DEB_ONE;
            end
          end else begin
            state_q   <= ST_SCAN;
            slot_q    <= '0;
            col_q     <= {col_q[2:0], col_q[3]};
            col_idx_q <= col_idx_q + 2'd1;
          end
        end
        ST_PRESSED: begin
          if (row_s_q == 4'b1111) begin
            state_q <= ST_RELEASE;
            deb_q   <= '0;
          end
        end
        ST_RELEASE: begin
          if (row_s_q == 4'b1111) begin
            if (deb_q == DEB_LAST) begin
              state_q     <= ST_SCAN;
              key_valid_q <= 1'b0;
              slot_q      <= '0;
              col_q       <= {col_q[2:0], col_q[3]};
              col_idx_q   <= col_idx_q + 2'd1;
            end else begin
              deb_q <= deb_q + DEB_ONE;
            end
          end else begin
            // Bounce during release: back to held, key_valid untouched.
            state_q <= ST_PRESSED;
          end
        end
        default: state_q <= ST_SCAN;
      endcase
    end
  end

  assign col_out   = col_q;
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a keypad model shorts row r to column c
// while key (r,c) is held; checks codes, edge counts and latencies.
module tb_keypad_scanner;

  localparam int unsigned SD = 4;
  localparam int unsigned DB = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] held;

  int          n_checks = 0;
  int          n_errors = 0;
  int          rises = 0;
  int          r0;
  int          cyc;
  logic        kv_prev = 1'b0;
  logic [3:0]  code_prev = 4'h0;
  logic [3:0]  rise_code = 4'h0;
  logic        col_bad = 1'b0;
  logic        code_bad = 1'b0;
  logic        kv_drop;

  logic [3:0] exp_map [16] = '{4'h1, 4'h2, 4'h3, 4'hC,
                               4'h4, 4'h5, 4'h6, 4'hD,
                               4'h7, 4'h8, 4'h9, 4'hE,
                               4'hA, 4'h0, 4'hB, 4'hF};

  always #5 clk = ~clk;

  always_comb begin
    row_in = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (held[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
  end

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CYCLES(DB)) dut (
    .clk      (clk),
    .rst      (rst),
    .row_in   (row_in),
    .col_out  (col_out),
    .key_valid(key_valid),
    .key_code (key_code)
  );

  // Edge log and continuous invariants, sampled on the falling edge.
  always @(negedge clk) begin
    if (key_valid && !kv_prev) begin
      rises++;
      rise_code = key_code;
    end else if (key_valid && key_code != code_prev) begin
      code_bad = 1'b1;
    end
    if (!(col_out inside {4'b1110, 4'b1101, 4'b1011, 4'b0111})) col_bad = 1'b1;
    kv_prev   = key_valid;
    code_prev = key_code;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_kv(input logic level, input int bound, output int c);
    c = 0;
    while (key_valid !== level && c <= bound) begin
      tick(1);
      c++;
    end
  endtask

  initial begin
    rst  = 1'b1;
    held = '0;
    tick(3);
    check("rst_col", col_out, 4'b1110);
    check("rst_kv", key_valid, 0);
    check("rst_code", key_code, 4'h0);
    rst = 1'b0;
    tick(5);

    // Clean press/release of '5'
    r0 = rises;
    held[5] = 1'b1;
    wait_kv(1'b1, 27, cyc);
    check("p5_lat_ok", (cyc >= 11 && cyc <= 27), 1);
    check("p5_code", key_code, 4'h5);
    tick(40 - cyc);
    held = '0;
    wait_kv(1'b0, 20, cyc);
    check("p5_rel_lat", cyc, 11);
    check("p5_rises", rises - r0, 1);
    check("p5_code_hold", key_code, 4'h5);
    tick(5);

    // Full key map
    r0 = rises;
    for (int k = 0; k < 16; k++) begin
      held = '0;
      held[k] = 1'b1;
      wait_kv(1'b1, 40, cyc);
      check($sformatf("map%0d_code", k), rise_code, exp_map[k]);
      tick(3);
      held = '0;
      wait_kv(1'b0, 20, cyc);
      tick(2);
    end
    check("map_rises", rises - r0, 16);
    check("map_col_onehot", col_bad, 0);

    // Press chatter on '#'
    r0 = rises;
    for (int i = 0; i < 20; i++) begin
      held[14] = ((i / 3) % 2) == 0;
      tick(1);
    end
    check("pb_no_kv", rises - r0, 0);
    held[14] = 1'b1;
    wait_kv(1'b1, 40, cyc);
    check("pb_rise_ok", (cyc <= 40), 1);
    check("pb_code", key_code, 4'hB);
    tick(5);
    check("pb_rises", rises - r0, 1);
    held = '0;
    wait_kv(1'b0, 20, cyc);
    tick(5);

    // Release chatter on '*'
    r0 = rises;
    kv_drop = 1'b0;
    held[12] = 1'b1;
    wait_kv(1'b1, 40, cyc);
    tick(3);
    for (int n = 0; n < 3; n++) begin
      held[12] = 1'b0;
      for (int j = 0; j < 2; j++) begin
        tick(1);
        if (!key_valid) kv_drop = 1'b1;
      end
      held[12] = 1'b1;
      for (int j = 0; j < 2; j++) begin
        tick(1);
        if (!key_valid) kv_drop = 1'b1;
      end
    end
    held = '0;
    wait_kv(1'b0, 20, cyc);
    check("rb_rel_lat", cyc, 11);
    check("rb_no_drop", kv_drop, 0);
    check("rb_rises", rises - r0, 1);
    check("rb_code", rise_code, 4'hA);
    tick(5);

    // Two keys in one column: rejected
    r0 = rises;
    held[0] = 1'b1;
    held[4] = 1'b1;
    tick(60);
    check("mk_same_col", rises - r0, 0);
    check("mk_kv_low", key_valid, 0);
    held = '0;
    tick(10);

    // Hold '2', then add '3' (other column) and '5' (same column)
    r0 = rises;
    held[1] = 1'b1;
    wait_kv(1'b1, 40, cyc);
    check("mk2_code", key_code, 4'h2);
    held[2] = 1'b1;
    tick(30);
    check("mk23_code", key_code, 4'h2);
    held[5] = 1'b1;
    tick(20);
    check("mk25_code", key_code, 4'h2);
    check("mk_kv_held", key_valid, 1);
    check("mk_rises", rises - r0, 1);
    held = '0;
    wait_kv(1'b0, 20, cyc);
    check("mk_rel_lat", cyc, 11);
    tick(5);

    // Reset while '7' is held
    held[8] = 1'b1;
    wait_kv(1'b1, 40, cyc);
    tick(5);
    r0 = rises;
    rst = 1'b1;
    #1;
    check("mr_kv", key_valid, 0);
    check("mr_col", col_out, 4'b1110);
    check("mr_code", key_code, 4'h0);
    tick(2);
    rst = 1'b0;
    wait_kv(1'b1, 40, cyc);
    check("mr_rerise_ok", (cyc >= 11 && cyc <= 40), 1);
    check("mr_code7", rise_code, 4'h7);
    check("mr_rises", rises - r0, 1);
    held = '0;
    wait_kv(1'b0, 20, cyc);
    tick(3);

    check("code_stable", code_bad, 0);
    check("col_onehot", col_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 active-low matrix keypad on the Pynq board, debounces presses and releases, and presents one decoded key at a time to the lock controller. It sits directly upstream of the lock FSM and drives its `key_valid` / `key_code` inputs. The lock FSM edge-detects `key_valid`, so each debounced press produces exactly one rising edge.

## Interface
- `SCAN_DIV`, default 125000: clock cycles per column slot (1 ms at 125 MHz). Minimum value is 4.
- `DEBOUNCE_CYCLES`, default 2500000: consecutive stable samples required for a press and for a release (20 ms). Minimum value is 2.
- `clk`, input, 1: system clock, 125 MHz.
- `rst`, input, 1: reset, asynchronous, active-high.
- `row_in`, input, 4: keypad rows, active-low with external pull-ups. Asynchronous to `clk`.
- `col_out`, output, 4: column drive, active-low, one-hot-low.
- `key_valid`, output, 1: high while a debounced key is held.
- `key_code`, output, 4: decoded key. Meaningful while `key_valid` is high. Holds its last value after release.

## Operation
- **Synchronizer:** `row_in` passes through a 2-flop synchronizer, producing `row_s`. All decisions use `row_s` only.
- **Key map** (index is [row][col]):
  - row0: 1, 2, 3, A → 4'h1, 4'h2, 4'h3, 4'hC
  - row1: 4, 5, 6, B → 4'h4, 4'h5, 4'h6, 4'hD
  - row2: 7, 8, 9, C → 4'h7, 4'h8, 4'h9, 4'hE
  - row3: *, 0, #, D → 4'hA, 4'h0, 4'hB, 4'hF
  - `*` = clear (4'hA) and `#` = confirm (4'hB), as the lock FSM expects.
- **SCAN state:**
  - A slot counter runs from 0 to SCAN_DIV-1.
  - At count SCAN_DIV-1, `row_s` is evaluated:
    - Exactly one bit low: latch the pattern and the code, clear the debounce counter, and go to DEBOUNCE. The column stays frozen.
    - Otherwise (none low, or two or more low): rotate `col_out` to the next column (0→1→2→3→0) and restart the slot counter.
- **DEBOUNCE state:**
  - Each cycle where `row_s` equals the latched pattern, increment the counter.
  - When DEBOUNCE_CYCLES matching samples have been counted, go to PRESSED. `key_valid` goes to 1 and `key_code` takes the latched code.
  - Any mismatch: return to SCAN and advance to the next column. No output change.
- **PRESSED state:**
  - `col_out` stays frozen.
  - `row_s` all ones: go to RELEASE with the counter cleared.
  - Any other pattern, including a second key in the same column: remain in PRESSED. The code is unchanged.
- **RELEASE state:**
  - `key_valid` stays 1.
  - Each cycle where `row_s` is 4'b1111, increment the counter.
  - After DEBOUNCE_CYCLES consecutive all-ones samples: go to SCAN, `key_valid` goes to 0, and the column advances.
  - Any row low: return to PRESSED with no `key_valid` glitch. A bounce does not produce a new edge.
- **Other keys:** keys in other columns are invisible while a column is frozen. This means no rollover; one key at a time.
- **Counter widths:** counters are sized to ceil(log2) of their parameter. There is no wrap-around within a state, because each counter is cleared on every state entry.

## Timing
- **Reset values:**
  - state = SCAN, slot and debounce counters = 0
  - `col_out` = 4'b1110 (column 0)
  - `key_valid` = 0, `key_code` = 4'h0
  - synchronizer flops = 4'b1111
- **Registered outputs:** all outputs are registered. There is no combinational path from `row_in`.
- **Press latency:**
  - Press on the column being driven, arriving just before a slot end: `key_valid` rises DEBOUNCE_CYCLES + 3 cycles after the `row_in` edge at minimum.
  - Worst case for any column: 4·SCAN_DIV + DEBOUNCE_CYCLES + 3 cycles.
- **Release latency:** `key_valid` falls DEBOUNCE_CYCLES + 3 cycles after the last rising edge of `row_in`.
- **Stability of `key_code`:** it changes only on the cycle `key_valid` rises. It is stable for the entire high period.
- **Column settling:** `col_out` changes only at slot boundaries. Rows are sampled SCAN_DIV-1 cycles after a change, which leaves 2 cycles of synchronizer plus settle margin.
- **Reset mid-press:** all state clears immediately. If the key is still held, it is re-scanned and re-debounced from scratch and yields a fresh `key_valid` rising edge.
- **Minimum pulse widths:** a `key_valid` high pulse lasts at least DEBOUNCE_CYCLES + 1 cycles. Consecutive presses are separated by at least DEBOUNCE_CYCLES cycles low.

## Test plan
All scenarios use SCAN_DIV=4 and DEBOUNCE_CYCLES=8. The keypad model shorts row r to column c while key (r,c) is held.

- **Clean press and release:** press `5` (row1, col1) for 40 cycles, then release. Required: exactly one `key_valid` high pulse with `key_code`=4'h5, and `key_valid` low 11 cycles after release.
- **Full key map:** press each of the 16 keys in turn. Required: code sequence 1,2,3,C,4,5,6,D,7,8,9,E,A,0,B,F, and `col_out` always one-hot-low.
- **Press bounce:** press `#` with 3-cycle on/off chatter for 20 cycles, then hold steady. Required: no `key_valid` during chatter, then a single rise with code 4'hB.
- **Release bounce:** hold `*`, then release with 2-cycle chatter 3 times. Required: `key_valid` stays 1 through the chatter and falls once, 11 cycles after the final release.
- **Multi-key:** press `1` and `4` simultaneously (same column, two rows). Required: no `key_valid`. Separately, hold `2`, then add `3`. Required: `key_code` stays 4'h2 and there is no second edge.
- **Reset mid-press:** assert `rst` while `7` is in PRESSED. Required: `key_valid`=0 and `col_out`=4'b1110 immediately. After deassertion with the key still held, `key_valid` rises again with code 4'h7.
